// File: rtl/scan_display_unit.sv
// Multiplexed hex display scanner: walks a window of an external entry array starting at
// base, one digit per scan tick, and drives active-low digit selects and segments.
// Compact mode stops at the first invalid entry; fixed mode scans all N_DIG slots.
module scan_display_unit #(
   parameter int unsigned N_DIG    = 8,
   parameter int unsigned DIV      = 10,
   parameter int unsigned BLINK_TK = 64,
   localparam int unsigned AW      = $clog2(N_DIG)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [N_DIG-1:0] valid,
   input  logic [3:0]       rd,
   input  logic [AW-1:0]    base,
   input  logic             mode,
   input  logic             blink_en,
   output logic [AW-1:0]    ra,
   output logic [N_DIG-1:0] an,
   output logic [6:0]       seg,
   output logic [3:0]       hex
);

   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned BW = (BLINK_TK > 1) ? $clog2(BLINK_TK) : 1;

   logic [PW-1:0]    presc_q, presc_d;
   logic             tick;
   logic [AW-1:0]    k_q, k_d;
   logic [AW-1:0]    ra_q, ra_d;
   logic [AW-1:0]    base_q, base_d;
   logic             mode_q, mode_d;
   logic             first_q, first_d;
   logic             pend_q, pend_d;
   logic             blank_q, blank_d;
   logic             phase_q, phase_d;
   logic [BW-1:0]    blink_q, blink_d;
   logic [N_DIG-1:0] an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic [3:0]       hex_q, hex_d;
   logic [AW-1:0]    k_inc, k_next, ent_inc;
   logic             cfg_chg;
   logic             lit;

   // Standard active-low hex decode, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex2seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Prescaler: one-cycle tick every DIV clocks.
   always_comb begin
      tick    = (presc_q == PW'(DIV - 1));
      presc_d = tick ? '0 : presc_q + 1'b1;
   end

   // Slot selection and read-address load on each tick.
   always_comb begin
      // First tick after reset and any base/mode change restart the scan at slot 0.
      cfg_chg = first_q | (base != base_q) | (mode != mode_q);
      k_inc   = k_q + 1'b1;
      ent_inc = base_q + k_inc;
      k_next  = '0;
      if (cfg_chg) begin
         k_next = '0;
      end else if (mode_q) begin
         k_next = k_inc;
      end else if ((k_q != AW'(N_DIG - 1)) && valid[ent_inc]) begin
         k_next = k_inc;
      end

      k_d     = k_q;
      ra_d    = ra_q;
      base_d  = base_q;
      mode_d  = mode_q;
      first_d = first_q;
      blank_d = blank_q;
      pend_d  = tick;
      if (tick) begin
         k_d     = k_next;
         ra_d    = base + k_next;
         base_d  = base;
         mode_d  = mode;
         first_d = 1'b0;
         // Blank decision uses the phase in force for this slot, before any toggle.
         blank_d = blink_en & ~phase_q;
      end
   end

   // Blink counter: counts ticks, toggles phase on wrap; parked while blinking is off.
   always_comb begin
      blink_d = blink_q;
      phase_d = phase_q;
      if (!blink_en) begin
         blink_d = '0;
         phase_d = 1'b1;
      end else if (tick) begin
         if (blink_q == BW'(BLINK_TK - 1)) begin
            blink_d = '0;
            phase_d = ~phase_q;
         end else begin
            blink_d = blink_q + 1'b1;
         end
      end
   end

   // Display update one cycle after the tick, from rd and valid[ra] of that cycle.
   always_comb begin
      lit   = valid[ra_q] & ~blank_q;
      an_d  = an_q;
      seg_d = seg_q;
      hex_d = hex_q;
      if (pend_q) begin
         // hex tracks the scanned entry even while blanked, but holds on invalid slots.
         if (valid[ra_q]) begin
            hex_d = rd;
         end
         if (lit) begin
            an_d  = ~({{(N_DIG-1){1'b0}}, 1'b1} << k_q);
            seg_d = hex2seg(rd);
         end else begin
            an_d  = '1;
            seg_d = 7'h7F;
         end
      end
   end

   // State registers with synchronous active-low reset; reset beats a same-cycle tick.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         presc_q <= '0;
         k_q     <= '0;
         ra_q    <= '0;
         base_q  <= '0;
         mode_q  <= 1'b0;
         first_q <= 1'b1;
         pend_q  <= 1'b0;
         blank_q <= 1'b0;
         phase_q <= 1'b1;
         blink_q <= '0;
         an_q    <= '1;
         seg_q   <= 7'h7F;
         hex_q   <= '0;
      end else begin
         presc_q <= presc_d;
         k_q     <= k_d;
         ra_q    <= ra_d;
         base_q  <= base_d;
         mode_q  <= mode_d;
         first_q <= first_d;
         pend_q  <= pend_d;
         blank_q <= blank_d;
         phase_q <= phase_d;
         blink_q <= blink_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         hex_q   <= hex_d;
      end
   end

   assign ra  = ra_q;
   assign an  = an_q;
   assign seg = seg_q;
   assign hex = hex_q;

endmodule

// File: tb/tb_scan_display_unit.sv
// Scoreboard bench for scan_display_unit: stimulus pushes expected per-tick displays,
// a monitor pops and checks them at each tick (ra) and the following display edge.
module tb_scan_display_unit;

   localparam int unsigned N_DIG    = 8;
   localparam int unsigned DIV      = 4;
   localparam int unsigned BLINK_TK = 2;

   typedef struct packed {
      logic [2:0] ra;
      logic [7:0] an;
      logic [6:0] seg;
      logic [3:0] hex;
   } exp_t;

   logic       clk = 1'b0;
   logic       rstn;
   logic [7:0] valid;
   logic [3:0] rd;
   logic [2:0] base;
   logic       mode;
   logic       blink_en;
   logic [2:0] ra;
   logic [7:0] an;
   logic [6:0] seg;
   logic [3:0] hex;
   logic [3:0] rd_off;

   exp_t sb[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   m_cnt   = 0;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   always #5 clk = ~clk;

   // External entry array: contents are address plus an offset.
   assign rd = {1'b0, ra} + rd_off;

   scan_display_unit #(
      .N_DIG   (N_DIG),
      .DIV     (DIV),
      .BLINK_TK(BLINK_TK)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .valid   (valid),
      .rd      (rd),
      .base    (base),
      .mode    (mode),
      .blink_en(blink_en),
      .ra      (ra),
      .an      (an),
      .seg     (seg),
      .hex     (hex)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic push(input logic [2:0] r, input logic [7:0] a, input logic [3:0] h);
      exp_t e;
      e.ra  = r;
      e.an  = a;
      e.hex = h;
      e.seg = (a == 8'hFF) ? 7'h7F : seg_tab[h];
      sb.push_back(e);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0) begin
         n_total++;
         $display("FAIL %s: %0d displays still pending, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic run_start(input logic md, input logic [2:0] b, input logic [7:0] v,
                            input logic [3:0] off, input logic bl);
      @(negedge clk);
      rstn     = 1'b0;
      mode     = md;
      base     = b;
      valid    = v;
      rd_off   = off;
      blink_en = bl;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   // Monitor: tracks tick timing, checks ra at tick edges and the display one edge later.
   initial begin
      exp_t       e;
      bit         rst_now, is_tick, is_disp;
      bit         disp_pend;
      logic [7:0] last_an;
      disp_pend = 1'b0;
      last_an   = 8'hFF;
      forever begin
         @(posedge clk);
         rst_now   = !rstn;
         is_disp   = disp_pend && !rst_now;
         is_tick   = !rst_now && (m_cnt == DIV - 1);
         disp_pend = is_tick;
         m_cnt     = rst_now ? 0 : ((m_cnt == DIV - 1) ? 0 : m_cnt + 1);
         if (rst_now) last_an = 8'hFF;
         #1;
         if (is_tick && sb.size() > 0) begin
            chk("ra_at_tick", ra, sb[0].ra);
            chk("an_lags_ra", an, last_an);
         end
         if (is_disp && sb.size() > 0) begin
            e = sb.pop_front();
            chk("ra", ra, e.ra);
            chk("an", an, e.an);
            chk("seg", seg, e.seg);
            chk("hex", hex, e.hex);
            last_an = e.an;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn     = 1'b0;
      valid    = 8'hFF;
      base     = 3'd0;
      mode     = 1'b1;
      blink_en = 1'b0;
      rd_off   = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ra", ra, 3'd0);
      chk("reset_an", an, 8'hFF);
      chk("reset_seg", seg, 7'h7F);
      chk("reset_hex", hex, 4'd0);

      // Fixed mode, all valid: digits 0..7 then wrap.
      run_start(1'b1, 3'd0, 8'hFF, 4'd0, 1'b0);
      push(0, 8'hFE, 0); push(1, 8'hFD, 1); push(2, 8'hFB, 2); push(3, 8'hF7, 3);
      push(4, 8'hEF, 4); push(5, 8'hDF, 5); push(6, 8'hBF, 6); push(7, 8'h7F, 7);
      push(0, 8'hFE, 0); push(1, 8'hFD, 1);
      drain("fixed_all");

      // Compact mode, three valid entries, letters on the display.
      run_start(1'b0, 3'd0, 8'b0000_0111, 4'd8, 1'b0);
      push(0, 8'hFE, 4'h8); push(1, 8'hFD, 4'h9); push(2, 8'hFB, 4'hA);
      push(0, 8'hFE, 4'h8); push(1, 8'hFD, 4'h9); push(2, 8'hFB, 4'hA);
      drain("compact_3");

      // Compact mode with address wrap-around.
      run_start(1'b0, 3'd6, 8'b1100_0011, 4'd0, 1'b0);
      push(6, 8'hFE, 6); push(7, 8'hFD, 7); push(0, 8'hFB, 0); push(1, 8'hF7, 1);
      push(6, 8'hFE, 6);
      drain("compact_wrap");

      // Compact mode with base entry invalid: dark, scan parked on base.
      run_start(1'b0, 3'd6, 8'b0000_0011, 4'd0, 1'b0);
      push(6, 8'hFF, 0); push(6, 8'hFF, 0); push(6, 8'hFF, 0);
      drain("compact_dark");

      // Fixed mode with a hole: slot 3 dark, hex holds previous digit.
      run_start(1'b1, 3'd0, 8'hF7, 4'd0, 1'b0);
      push(0, 8'hFE, 0); push(1, 8'hFD, 1); push(2, 8'hFB, 2); push(3, 8'hFF, 2);
      push(4, 8'hEF, 4);
      drain("fixed_hole");

      // Fixed mode, base change mid-scan restarts at slot 0 of the new base.
      run_start(1'b1, 3'd0, 8'hFF, 4'd0, 1'b0);
      push(0, 8'hFE, 0); push(1, 8'hFD, 1); push(2, 8'hFB, 2);
      drain("base_pre");
      base = 3'd5;
      push(5, 8'hFE, 5); push(6, 8'hFD, 6); push(7, 8'hFB, 7);
      drain("base_change");

      // Blink with BLINK_TK=2: two ticks lit, two blanked, scan keeps going.
      run_start(1'b1, 3'd0, 8'hFF, 4'd0, 1'b1);
      push(0, 8'hFE, 0); push(1, 8'hFD, 1); push(2, 8'hFF, 2); push(3, 8'hFF, 3);
      push(4, 8'hEF, 4); push(5, 8'hDF, 5);
      drain("blink");

      // One-cycle reset landing on a tick edge.
      run_start(1'b1, 3'd3, 8'hFF, 4'd0, 1'b0);
      push(3, 8'hFE, 3); push(4, 8'hFD, 4); push(5, 8'hFB, 5);
      drain("pre_reset");
      for (int i = 0; i < 2 * DIV && m_cnt != DIV - 1; i++) @(negedge clk);
      rstn = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_ra", ra, 3'd0);
      chk("midrst_an", an, 8'hFF);
      chk("midrst_seg", seg, 7'h7F);
      chk("midrst_hex", hex, 4'd0);
      @(negedge clk);
      rstn = 1'b1;
      push(3, 8'hFE, 3); push(4, 8'hFD, 4);
      drain("post_reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/scan_display_unit.md
SCAN_DISPLAY_UNIT -- requirements
Module: scan_display_unit

Interface
REQ-001 The block SHALL have the following parameters:
- N_DIG, default 8: digit/entry count, power of two, 2..16.
- DIV, default 10: clk cycles per scan tick, >=2.
- BLINK_TK, default 64: scan ticks per blink half-period.
REQ-002 AW SHALL equal clog2(N_DIG) and SHALL be derived, not user-set.
REQ-003 The block SHALL have the following ports, clock and reset first:
- clk  in  1: sole clock, all logic on the rising edge.
- rstn  in  1: synchronous, active-low reset.
- valid  in  N_DIG: per-entry valid mask, indexed by entry address.
- rd  in  4: hex data of entry ra, combinational from the external array.
- base  in  AW: first entry to display.
- mode  in  1: 0 = compact, 1 = fixed.
- blink_en  in  1: enables blinking of all digits.
- ra  out  AW: registered read address to the external array.
- an  out  N_DIG: registered one-hot digit select, active-low.
- seg  out  7: registered segments {g,f,e,d,c,b,a}, active-low.
- hex  out  4: registered raw nibble currently displayed.

Function
REQ-004 The prescaler SHALL count 0..DIV-1 and assert an internal tick for one cycle when the count equals DIV-1, then wrap to 0.
REQ-005 Slot counter k (0..N_DIG-1) SHALL advance only on tick cycles.
REQ-006 Address arithmetic SHALL be modulo N_DIG: entry(k) = (base + k) mod N_DIG (e.g. N_DIG=8, base=6, k=3 gives 1).
REQ-007 On each tick edge, ra SHALL be loaded with entry(k_next), where k_next is the slot selected for this tick.
REQ-008 an, seg and hex SHALL update exactly one cycle after ra, from rd and valid[ra] sampled in that cycle; latency from tick to display is 1 clk.
REQ-009 Fixed mode: k_next SHALL be k+1, wrapping N_DIG-1 to 0.
REQ-010 Fixed mode: an SHALL drive bit k low only if valid[entry(k)]=1, otherwise all ones.
REQ-011 Compact mode: k_next SHALL be k+1 while k+1 <= N_DIG-1 and valid[entry(k+1)]=1, otherwise 0.
REQ-012 Compact mode: when valid[base]=0, an SHALL stay all ones and k SHALL stay 0.
REQ-013 When an is all ones, seg SHALL be 7'h7F and hex SHALL hold its last value.
REQ-014 seg SHALL use the standard active-low hex decode, 0 -> 7'h40 through F -> 7'h0E (A=08, b=03, C=46, d=21, E=06).
REQ-015 The block SHALL register mode and base internally.
REQ-016 A change of mode or base SHALL force k_next = 0 on the next tick; within that tick's slot, the new values SHALL be in effect.
REQ-017 Blink: a blink counter SHALL count ticks 0..BLINK_TK-1 and toggle a phase bit on wrap.
REQ-018 While blink_en=1 and phase=off, an SHALL be all ones and seg SHALL be 7'h7F; scanning, ra and hex SHALL continue unchanged.
REQ-019 While blink_en=0, phase SHALL be forced to on and the blink counter SHALL be held at 0.
REQ-020 A valid bit dropping mid-scan SHALL take effect at the next tick; no output SHALL glitch between ticks.

Reset
REQ-021 With rstn=0 at a clk edge, the block SHALL set prescaler=0, k=0, ra=0, an=all ones, seg=7'h7F, hex=0, blink counter=0, phase=on, and registered base/mode=0.
REQ-022 The first tick after reset release SHALL occur DIV cycles after the first edge with rstn=1.
REQ-023 A reset asserted mid-scan SHALL override any tick in the same cycle.

Verification
REQ-024 The bench SHALL run fixed mode, N_DIG=8, DIV=4, valid=8'hFF, base=0, rd=addr -> an steps FE,FD,...,7F; seg shows 0..7; period 4 clk; seg/an lag ra by 1 clk.
REQ-025 The bench SHALL run compact mode, valid=8'b0000_0111, base=0 -> ra cycles 0,1,2,0,...; an cycles FE,FD,FB; digits 3..7 never lit.
REQ-026 The bench SHALL run compact mode, base=6, valid=8'b1100_0011 -> ra sequence 6,7,0,1,6,... (wrap-around); valid[base]=0 -> an stays FF.
REQ-027 The bench SHALL run fixed mode, change base 0->5 mid-scan -> next tick ra=5 and an=FE.
REQ-028 The bench SHALL run blink_en=1, BLINK_TK=2 -> an alternates 2 ticks lit / 2 ticks FF while ra keeps advancing.
REQ-029 The bench SHALL assert rstn=0 for 1 cycle mid-scan coincident with a tick -> all outputs at reset values; next tick occurs exactly DIV cycles later with ra=entry(0).
